mac_unit_vert_seq_module: RTL and testbench

Parametrised, self-sequencing successor to the 16-lane vertical bit-column MAC. It latches one activation vector and its per-group sums, then consumes one weight bit-column per handshake beat, generating the column shift and MSB negation internally. Partial sums pass through a registered stage into an accumulator, and the final dot product is held on a valid/ready output. The block sits between the column scheduler, which supplies select and skip metadata, and the PE-row output collector.

---
 rtl/mac_unit_vert_seq_module.sv | 177 +++++++++++++++++
 tb/tb_mac_unit_vert_seq_module.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_unit_vert_seq_module.sv
// Self-sequencing vertical bit-column MAC: latches an activation vector and
// its per-group sums, consumes one weight bit-column per handshake beat,
// accumulates the shifted partial sums and holds the dot product on a
// valid/ready output.
module mac_unit_vert_seq_module #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_GROUPS   = 2,
    parameter int GROUP_SIZE   = 8,
    parameter int WEIGHT_BITS  = 8,
    parameter int SUM_WIDTH    = DATA_WIDTH + $clog2(GROUP_SIZE),
    parameter int RESULT_WIDTH = DATA_WIDTH + 14,
    localparam int VEC_LENGTH    = NUM_GROUPS * GROUP_SIZE,
    localparam int SEL_PER_GROUP = GROUP_SIZE / 2,
    localparam int SEL_WIDTH     = $clog2(GROUP_SIZE + 1),
    localparam int HAM_WIDTH     = $clog2(VEC_LENGTH + 1)
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          vec_valid,
    output logic                                          vec_ready,
    input  logic [DATA_WIDTH*VEC_LENGTH-1:0]              act,
    input  logic [SUM_WIDTH*NUM_GROUPS-1:0]               sum_act,
    input  logic                                          col_valid,
    output logic                                          col_ready,
    input  logic [SEL_WIDTH*NUM_GROUPS*SEL_PER_GROUP-1:0] act_sel,
    input  logic [NUM_GROUPS-1:0]                         is_skip_zero,
    input  logic [HAM_WIDTH-1:0]                          hamming_sel,
    input  logic                                          hamming_sign,
    input  logic [2:0]                                    mul_const,
    input  logic                                          is_shift_mul,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [RESULT_WIDTH-1:0]                       result
);

    localparam int CNT_WIDTH = (WEIGHT_BITS > 1) ? $clog2(WEIGHT_BITS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_OUT
    } state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0]   act_r [VEC_LENGTH];
    logic [SUM_WIDTH-1:0]    sum_r [NUM_GROUPS];
    logic [RESULT_WIDTH-1:0] acc;
    logic [RESULT_WIDTH-1:0] s1;
    logic                    s1_valid;
    logic [CNT_WIDTH-1:0]    col_cnt;

    logic vec_fire;
    logic col_fire;
    logic last_col;

    logic [RESULT_WIDTH-1:0] psum;
    logic [RESULT_WIDTH-1:0] true_sum;
    logic [RESULT_WIDTH-1:0] tot;
    logic [RESULT_WIDTH-1:0] sum_total;
    logic [RESULT_WIDTH-1:0] mul;
    logic [RESULT_WIDTH-1:0] ham;
    logic [RESULT_WIDTH-1:0] s1_next;

    function automatic logic [RESULT_WIDTH-1:0] sext_act(input logic [DATA_WIDTH-1:0] a);
        return {{(RESULT_WIDTH-DATA_WIDTH){a[DATA_WIDTH-1]}}, a};
    endfunction

    function automatic logic [RESULT_WIDTH-1:0] sext_sum(input logic [SUM_WIDTH-1:0] a);
        return {{(RESULT_WIDTH-SUM_WIDTH){a[SUM_WIDTH-1]}}, a};
    endfunction

    assign vec_fire = vec_valid && vec_ready;
    assign col_fire = col_valid && col_ready;
    assign last_col = (col_cnt == CNT_WIDTH'(WEIGHT_BITS - 1));
    assign result   = acc;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        vec_ready  = 1'b0;
        col_ready  = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                vec_ready = 1'b1;
                if (vec_valid) state_next = ST_RUN;
            end
            ST_RUN: begin
                col_ready = 1'b1;
                if (col_valid && last_col) state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                state_next = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Per-beat stage-1 value from the latched vector and the current column inputs;
    // selector matching is a compare-per-candidate loop so out-of-range selects
    // simply match nothing and contribute zero.
    always_comb begin
        psum      = '0;
        true_sum  = '0;
        tot       = '0;
        sum_total = '0;
        ham       = '0;
        for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
            psum = '0;
            for (int unsigned s = 0; s < SEL_PER_GROUP; s++) begin
                for (int unsigned j = 0; j < GROUP_SIZE; j++) begin
                    if (act_sel[(g*SEL_PER_GROUP+s)*SEL_WIDTH +: SEL_WIDTH] == SEL_WIDTH'(j)) begin
                        psum = psum + sext_act(act_r[g*GROUP_SIZE+j]);
                    end
                end
            end
            true_sum  = is_skip_zero[g] ? psum : (sext_sum(sum_r[g]) - psum);
            tot       = tot + true_sum;
            sum_total = sum_total + sext_sum(sum_r[g]);
        end
        if (last_col) tot = -tot;

        mul = sum_total * RESULT_WIDTH'(mul_const);
        if (is_shift_mul) mul = mul << 3;

        for (int unsigned i = 0; i < VEC_LENGTH; i++) begin
            if (hamming_sel == HAM_WIDTH'(i)) ham = sext_act(act_r[i]);
        end
        if (hamming_sign) ham = -ham;

        s1_next = (tot << col_cnt) + mul + (ham << col_cnt);
    end

    // Operand latch, stage-1 register, column counter and accumulator
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc      <= '0;
            s1       <= '0;
            s1_valid <= 1'b0;
            col_cnt  <= '0;
        end else begin
            if (vec_fire) begin
                for (int unsigned i = 0; i < VEC_LENGTH; i++) begin
                    act_r[i] <= act[i*DATA_WIDTH +: DATA_WIDTH];
                end
                for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
                    sum_r[g] <= sum_act[g*SUM_WIDTH +: SUM_WIDTH];
                end
                acc     <= '0;
                col_cnt <= '0;
            end else if (s1_valid) begin
                acc <= acc + s1;
            end
            s1_valid <= col_fire;
            if (col_fire) begin
                s1      <= s1_next;
                col_cnt <= col_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_mac_unit_vert_seq_module.sv
// Directed bench for mac_unit_vert_seq_module with hand-computed results.
module tb_mac_unit_vert_seq_module;

    localparam int DW    = 8;
    localparam int NG    = 2;
    localparam int GS    = 8;
    localparam int WB    = 8;
    localparam int SW    = 11;
    localparam int RW    = 22;
    localparam int VL    = 16;
    localparam int SPG   = 4;
    localparam int SELW  = 4;
    localparam int HAMW  = 5;
    localparam int NSLOT = NG * SPG;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  vec_valid;
    logic                  vec_ready;
    logic [DW*VL-1:0]      act;
    logic [SW*NG-1:0]      sum_act;
    logic                  col_valid;
    logic                  col_ready;
    logic [SELW*NSLOT-1:0] act_sel;
    logic [NG-1:0]         is_skip_zero;
    logic [HAMW-1:0]       hamming_sel;
    logic                  hamming_sign;
    logic [2:0]            mul_const;
    logic                  is_shift_mul;
    logic                  out_valid;
    logic                  out_ready;
    logic [RW-1:0]         result;

    logic [SELW*NSLOT-1:0] t_sel   [WB];
    logic [NG-1:0]         t_skip  [WB];
    logic [HAMW-1:0]       t_hsel  [WB];
    logic                  t_hsign [WB];
    logic [2:0]            t_mul   [WB];
    logic                  t_shift [WB];

    int checks = 0;
    int errors = 0;

    mac_unit_vert_seq_module #(
        .DATA_WIDTH  (DW),
        .NUM_GROUPS  (NG),
        .GROUP_SIZE  (GS),
        .WEIGHT_BITS (WB),
        .SUM_WIDTH   (SW),
        .RESULT_WIDTH(RW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .vec_valid   (vec_valid),
        .vec_ready   (vec_ready),
        .act         (act),
        .sum_act     (sum_act),
        .col_valid   (col_valid),
        .col_ready   (col_ready),
        .act_sel     (act_sel),
        .is_skip_zero(is_skip_zero),
        .hamming_sel (hamming_sel),
        .hamming_sign(hamming_sign),
        .mul_const   (mul_const),
        .is_shift_mul(is_shift_mul),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // first n slots of each group select indices 0..n-1, the rest select 8 (zero)
    function automatic logic [SELW*NSLOT-1:0] sel_first(input int n);
        logic [SELW*NSLOT-1:0] v;
        v = '0;
        for (int k = 0; k < NSLOT; k++) begin
            v[k*SELW +: SELW] = ((k % SPG) < n) ? SELW'(k % SPG) : SELW'(8);
        end
        return v;
    endfunction

    task automatic clear_cols();
        for (int c = 0; c < WB; c++) begin
            t_sel[c]   = sel_first(0);
            t_skip[c]  = 2'b11;
            t_hsel[c]  = HAMW'(VL);
            t_hsign[c] = 1'b0;
            t_mul[c]   = 3'd0;
            t_shift[c] = 1'b0;
        end
    endtask

    task automatic set_all_act(input int v);
        for (int i = 0; i < VL; i++) act[i*DW +: DW] = DW'(v);
    endtask

    task automatic set_sums(input int s0, input int s1v);
        sum_act[0 +: SW]  = SW'(s0);
        sum_act[SW +: SW] = SW'(s1v);
    endtask

    task automatic setup_scn1();
        set_all_act(1);
        set_sums(8, 8);
        clear_cols();
        for (int c = 0; c < WB; c++) t_sel[c] = sel_first(4);
    endtask

    task automatic load_vec();
        @(negedge clk);
        chk("vec_ready_idle", int'(vec_ready), 1);
        vec_valid = 1'b1;
        @(negedge clk);
        vec_valid = 1'b0;
        chk("vec_ready_run", int'(vec_ready), 0);
    endtask

    task automatic run_cols(input int nbeats, input int gap);
        for (int c = 0; c < nbeats; c++) begin
            act_sel      = t_sel[c];
            is_skip_zero = t_skip[c];
            hamming_sel  = t_hsel[c];
            hamming_sign = t_hsign[c];
            mul_const    = t_mul[c];
            is_shift_mul = t_shift[c];
            col_valid    = 1'b1;
            chk("col_ready_run", int'(col_ready), 1);
            @(negedge clk);
            col_valid = 1'b0;
            if (c != nbeats - 1) begin
                for (int b = 0; b < gap; b++) begin
                    act_sel      = '0;
                    is_skip_zero = '0;
                    hamming_sel  = '0;
                    hamming_sign = 1'b1;
                    mul_const    = 3'd7;
                    is_shift_mul = 1'b1;
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic finish_vec(input string tag, input int exp);
        chk("flush_out_valid", int'(out_valid), 0);
        chk("flush_col_ready", int'(col_ready), 0);
        chk("flush_vec_ready", int'(vec_ready), 0);
        @(negedge clk);
        chk("out_valid", int'(out_valid), 1);
        chk(tag, int'($signed(result)), exp);
        @(negedge clk);
        chk("idle_out_valid", int'(out_valid), 0);
        chk("idle_vec_ready", int'(vec_ready), 1);
    endtask

    initial begin
        reset        = 1'b0;
        vec_valid    = 1'b0;
        col_valid    = 1'b0;
        out_ready    = 1'b1;
        act          = '0;
        sum_act      = '0;
        act_sel      = '0;
        is_skip_zero = '0;
        hamming_sel  = '0;
        hamming_sign = 1'b0;
        mul_const    = 3'd0;
        is_shift_mul = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_result", int'($signed(result)), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_col_ready", int'(col_ready), 0);
        chk("rst_vec_ready", int'(vec_ready), 1);
        reset = 1'b1;

        // scenario 1: 8*127 - 8*128
        setup_scn1();
        load_vec();
        run_cols(WB, 0);
        finish_vec("scn1_result", -8);

        // scenario 2: column 0 uses sum_act - psum = 15 per group
        set_all_act(3);
        set_sums(24, 24);
        clear_cols();
        t_sel[0]  = sel_first(3);
        t_skip[0] = 2'b00;
        load_vec();
        run_cols(WB, 0);
        finish_vec("scn2_result", 30);

        // scenario 3: mul term 7*5<<3 = 280 plus negated hamming 6 at column 0
        set_all_act(0);
        act[3*DW +: DW] = 8'hFA;
        set_sums(10, -3);
        clear_cols();
        t_mul[0] = 3'd5; t_shift[0] = 1'b1; t_hsel[0] = 5'd3; t_hsign[0] = 1'b1;
        load_vec();
        run_cols(WB, 0);
        finish_vec("scn3_col0_result", 286);

        // scenario 3 at column 2: hamming shifted by 2 -> 280 + 24
        clear_cols();
        t_mul[2] = 3'd5; t_shift[2] = 1'b1; t_hsel[2] = 5'd3; t_hsign[2] = 1'b1;
        load_vec();
        run_cols(WB, 0);
        finish_vec("scn3_col2_result", 304);

        // backpressure: hold the result for 5 cycles with stray valids asserted
        setup_scn1();
        out_ready = 1'b0;
        load_vec();
        run_cols(WB, 0);
        chk("bp_flush_out_valid", int'(out_valid), 0);
        @(negedge clk);
        vec_valid = 1'b1;
        col_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_result", int'($signed(result)), -8);
            chk("bp_vec_ready", int'(vec_ready), 0);
            chk("bp_col_ready", int'(col_ready), 0);
            @(negedge clk);
        end
        vec_valid = 1'b0;
        col_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle_out_valid", int'(out_valid), 0);
        chk("bp_idle_vec_ready", int'(vec_ready), 1);

        // reset after the column-4 beat discards the operation
        setup_scn1();
        load_vec();
        run_cols(5, 0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_vec_ready", int'(vec_ready), 1);
        chk("midrst_col_ready", int'(col_ready), 0);
        chk("midrst_result", int'($signed(result)), 0);
        load_vec();
        run_cols(WB, 0);
        finish_vec("post_rst_result", -8);

        // two-cycle bubbles between beats with garbage column inputs
        setup_scn1();
        load_vec();
        run_cols(WB, 2);
        finish_vec("bubble_result", -8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
